// File: rtl/key_envelope_adsr_if.sv
// rtl/key_envelope_adsr_if.sv - key input, tone sample and envelope outputs of one voice
interface key_envelope_adsr_if;
  logic        key_n;
  logic [10:0] sample_in;
  logic        gate;
  logic        active;
  logic [7:0]  env_level;
  logic [10:0] sample_out;

  modport master (
    output key_n,
    output sample_in,
    input  gate,
    input  active,
    input  env_level,
    input  sample_out
  );

  modport slave (
    input  key_n,
    input  sample_in,
    output gate,
    output active,
    output env_level,
    output sample_out
  );
endinterface

// File: rtl/key_envelope_adsr.sv
// rtl/key_envelope_adsr.sv - key debounce, ADSR envelope and tone scaling for one voice
module key_envelope_adsr #(
  parameter int DEBOUNCE_CYC = 240000,
  parameter int TICK_DIV     = 4800,
  parameter int ATTACK_STEP  = 8,
  parameter int DECAY_STEP   = 2,
  parameter int SUSTAIN_LVL  = 160,
  parameter int RELEASE_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  key_envelope_adsr_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic [TK_W-1:0] r_tick_cnt;
  state_t          r_state;
  logic [7:0]      r_env;
  logic            r_active;
  logic [10:0]     r_sample_out;

  logic            w_gate;
  logic            w_tick;
  logic [8:0]      w_att_sum;
  logic [18:0]     w_product;

  // Stable holds the debounced raw pin level, so 1 means released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        if (r_db_cnt == DB_LAST) begin
          r_stable <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_gate = ~r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

  assign w_tick    = (r_tick_cnt == TK_LAST);
  assign w_att_sum = {1'b0, r_env} + 9'(ATTACK_STEP);

  // Gate changes are tested before the tick so a coincident tick leaves env untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_env    <= 8'd0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_env <= 8'd0;
          if (w_gate) begin
            r_state  <= S_ATTACK;
            r_active <= 1'b1;
          end
        end
        S_ATTACK: begin
          if (!w_gate) begin
            r_state <= S_RELEASE;
          end else if (w_tick) begin
            if (w_att_sum >= 9'd255) begin
              r_env   <= 8'd255;
              r_state <= S_DECAY;
            end else begin
              r_env <= w_att_sum[7:0];
            end
          end
        end
        S_DECAY: begin
          if (!w_gate) begin
            r_state <= S_RELEASE;
          end else if ({1'b0, r_env} <= 9'(SUSTAIN_LVL)) begin
            r_state <= S_SUSTAIN;
          end else if (w_tick) begin
            if ({1'b0, r_env} <= 9'(SUSTAIN_LVL) + 9'(DECAY_STEP)) begin
              r_env   <= 8'(SUSTAIN_LVL);
              r_state <= S_SUSTAIN;
            end else begin
              r_env <= r_env - 8'(DECAY_STEP);
            end
          end
        end
        S_SUSTAIN: begin
          if (!w_gate) begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_gate) begin
            r_state <= S_ATTACK;
          end else if (w_tick) begin
            if ({1'b0, r_env} <= 9'(RELEASE_STEP)) begin
              r_env    <= 8'd0;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_env <= r_env - 8'(RELEASE_STEP);
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_env    <= 8'd0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign w_product = {8'd0, bus.sample_in} * {11'd0, r_env};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_out <= 11'd0;
    end else begin
      r_sample_out <= 11'(w_product >> 8);
    end
  end

  assign bus.gate       = w_gate;
  assign bus.active     = r_active;
  assign bus.env_level  = r_env;
  assign bus.sample_out = r_sample_out;

endmodule

// File: tb/tb_key_envelope_adsr.sv
// tb/tb_key_envelope_adsr.sv - directed bench for key_envelope_adsr with small sim parameters
module tb_key_envelope_adsr;

  logic clk;
  logic rst;
  key_envelope_adsr_if bus ();

  key_envelope_adsr #(
    .DEBOUNCE_CYC (4),
    .TICK_DIV     (2),
    .ATTACK_STEP  (64),
    .DECAY_STEP   (32),
    .SUSTAIN_LVL  (128),
    .RELEASE_STEP (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] sample;
    logic [10:0] exp_out;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   got[$];
  int   exp_q[$];
  vec_t vecs[6];
  int   prev_env;
  bit   repressed;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name);
    check({name, " length"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{11'd2047, 11'd1023};
    vecs[1] = '{11'd0,    11'd0};
    vecs[2] = '{11'd1,    11'd0};
    vecs[3] = '{11'd3,    11'd1};
    vecs[4] = '{11'd1000, 11'd500};
    vecs[5] = '{11'd1365, 11'd682};

    // Reset held with the key pressed and a full-scale tone
    rst           = 1'b1;
    bus.key_n     = 1'b0;
    bus.sample_in = 11'd2047;
    repeat (6) begin
      @(negedge clk);
      check("rst gate", bus.gate, 0);
      check("rst active", bus.active, 0);
      check("rst env", bus.env_level, 0);
      check("rst sample_out", bus.sample_out, 0);
    end
    bus.key_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle gate", bus.gate, 0);
    check("idle active", bus.active, 0);

    // Bounce every 2 clocks, then a clean press
    for (int c = 0; c < 20; c++) begin
      bus.key_n = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("bounce gate", bus.gate, 0);
    end
    bus.key_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("press gate at clk %0d", k), bus.gate, (k == 6) ? 1 : 0);
    end

    // Attack and decay into sustain, with output scaling spot checks
    got.delete();
    prev_env = 0;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      @(negedge clk);
      if (prev_env == 255) check("sample_out at env 255", bus.sample_out, 2039);
      if (prev_env == 128) check("sample_out at env 128", bus.sample_out, 1023);
      if (prev_env == 0)   check("sample_out at env 0", bus.sample_out, 0);
      if (int'(bus.env_level) != prev_env) got.push_back(int'(bus.env_level));
      prev_env = int'(bus.env_level);
    end
    exp_q = '{64, 128, 192, 255, 223, 191, 159, 128};
    check_seq("attack/decay env");
    repeat (10) @(negedge clk);
    check("sustain env", bus.env_level, 128);
    check("sustain active", bus.active, 1);

    for (int i = 0; i < 6; i++) begin
      bus.sample_in = vecs[i].sample;
      @(negedge clk);
      check($sformatf("vec%0d sample_out", i), bus.sample_out, vecs[i].exp_out);
      check($sformatf("vec%0d env", i), bus.env_level, 128);
    end
    bus.sample_in = 11'd2047;

    // Release from sustain down to idle
    bus.key_n = 1'b1;
    got.delete();
    prev_env = 128;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      @(negedge clk);
      if (int'(bus.env_level) != prev_env) got.push_back(int'(bus.env_level));
      prev_env = int'(bus.env_level);
    end
    exp_q = '{112, 96, 80, 64, 48, 32, 16, 0};
    check_seq("release env");
    check("release active", bus.active, 0);
    @(negedge clk);
    check("release sample_out", bus.sample_out, 0);
    repeat (4) @(negedge clk);

    // Release part-way through attack, re-press part-way through release
    bus.key_n = 1'b0;
    repeat (5) @(negedge clk);
    bus.key_n = 1'b1;
    got.delete();
    prev_env  = 0;
    repressed = 1'b0;
    for (int c = 0; c < 100 && got.size() < 9; c++) begin
      @(negedge clk);
      if (int'(bus.env_level) != prev_env) got.push_back(int'(bus.env_level));
      prev_env = int'(bus.env_level);
      if (prev_env == 112 && !repressed) begin
        bus.key_n = 1'b0;
        repressed = 1'b1;
      end
    end
    exp_q = '{64, 128, 112, 96, 80, 64, 128, 192, 255};
    check_seq("retrigger env");
    repeat (20) @(negedge clk);
    check("retrigger sustain env", bus.env_level, 128);
    check("retrigger gate", bus.gate, 1);

    // One-clock reset pulse in sustain
    #2 rst = 1'b1;
    #1;
    check("midnote rst gate", bus.gate, 0);
    check("midnote rst active", bus.active, 0);
    check("midnote rst env", bus.env_level, 0);
    check("midnote rst sample_out", bus.sample_out, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("post-rst gate at clk %0d", k), bus.gate, (k >= 6) ? 1 : 0);
      check($sformatf("post-rst active at clk %0d", k), bus.active, (k == 7) ? 1 : 0);
      check($sformatf("post-rst env at clk %0d", k), bus.env_level, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
